// File: rtl/if_fetch_stage_if.sv
// -----------------------------------------------------------------------------
// if_fetch_stage_if
// Bundles the fetch-stage control inputs, instruction-memory link, IF/ID
// register outputs and display counters into one interface.
//   master : upstream/control side (drives pc_enable, stall, redirect,
//            redirect_target, instr_in; observes everything else)
//   slave  : the fetch stage itself
// -----------------------------------------------------------------------------
interface if_fetch_stage_if;
  logic        pc_enable;        // 1 = run, 0 = halted
  logic        stall;            // load-use hazard hold
  logic        redirect;         // taken branch / jump resolved in EX
  logic [31:0] redirect_target;  // new PC, low two bits ignored
  logic [31:0] instr_in;         // combinational imem data for pc
  logic [31:0] pc;               // current fetch address
  logic [31:0] if_id_instr;      // IF/ID instruction
  logic [31:0] if_id_pc4;        // IF/ID PC+4
  logic        if_id_valid;      // IF/ID holds a real instruction
  logic [31:0] fetch_count;      // instructions loaded into IF/ID (wraps)
  logic [15:0] redirect_count;   // redirects applied to PC (saturates)

  modport master (
    output pc_enable, stall, redirect, redirect_target, instr_in,
    input  pc, if_id_instr, if_id_pc4, if_id_valid, fetch_count, redirect_count
  );

  modport slave (
    input  pc_enable, stall, redirect, redirect_target, instr_in,
    output pc, if_id_instr, if_id_pc4, if_id_valid, fetch_count, redirect_count
  );
endinterface

// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
// Instruction-fetch stage: owns the PC, addresses instruction memory and
// loads the IF/ID register. A redirect seen while halted is parked and
// applied on the first running edge.
// Ports:
//   clk  : single clock, rising-edge state updates
//   rst  : asynchronous active-high reset
//   bus  : if_fetch_stage_if.slave (control in, imem data in, IF/ID and
//          counters out)
// Parameter:
//   RESET_PC : PC value after reset
// -----------------------------------------------------------------------------
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  if_fetch_stage_if.slave bus
);

  // ST_PENDING means a redirect arrived while halted and is waiting for resume
  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_PENDING = 1'b1
  } redir_state_e;

  redir_state_e state_r, state_s;
  logic [31:0]  pend_tgt_r, pend_tgt_s;
  logic [31:0]  pc_r, pc_s;
  logic [31:0]  instr_r, instr_s;
  logic [31:0]  pc4_r, pc4_s;
  logic         valid_r, valid_s;
  logic [31:0]  fcnt_r, fcnt_s;
  logic [15:0]  rcnt_r, rcnt_s;
  logic [31:0]  pc_plus4_s;
  logic [31:0]  tgt_aligned_s;

  // Saturating increment for the display redirect counter
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    logic [15:0] r;
    if (v == 16'hFFFF) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

  assign pc_plus4_s    = pc_r + 32'd4;
  // Masking keeps the low bits out of the PC without leaving them dangling
  assign tgt_aligned_s = bus.redirect_target & 32'hFFFF_FFFC;

  // Next-state selection: redirect > parked redirect on resume > halt > stall > fetch
  always_comb begin
    state_s    = state_r;
    pend_tgt_s = pend_tgt_r;
    pc_s       = pc_r;
    instr_s    = instr_r;
    pc4_s      = pc4_r;
    valid_s    = valid_r;
    fcnt_s     = fcnt_r;
    rcnt_s     = rcnt_r;
    if (bus.redirect && bus.pc_enable) begin
      pc_s    = tgt_aligned_s;
      instr_s = 32'h0000_0000;
      pc4_s   = 32'h0000_0000;
      valid_s = 1'b0;
      state_s = ST_RUN;
      rcnt_s  = sat_inc16(rcnt_r);
    end else if (bus.redirect) begin
      // Halted: park the newest target, flush now, PC waits for resume
      pend_tgt_s = tgt_aligned_s;
      state_s    = ST_PENDING;
      instr_s    = 32'h0000_0000;
      pc4_s      = 32'h0000_0000;
      valid_s    = 1'b0;
    end else if ((state_r == ST_PENDING) && bus.pc_enable) begin
      // Resume edge: parked target wins even over a stall
      pc_s    = pend_tgt_r;
      instr_s = 32'h0000_0000;
      pc4_s   = 32'h0000_0000;
      valid_s = 1'b0;
      state_s = ST_RUN;
      rcnt_s  = sat_inc16(rcnt_r);
    end else if (!bus.pc_enable) begin
      pc_s = pc_r;
    end else if (bus.stall) begin
      pc_s = pc_r;
    end else begin
      pc_s    = pc_plus4_s;
      instr_s = bus.instr_in;
      pc4_s   = pc_plus4_s;
      valid_s = 1'b1;
      fcnt_s  = fcnt_r + 32'd1;
    end
  end

  // State register with asynchronous reset; reset also discards a parked redirect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_RUN;
      pend_tgt_r <= 32'h0000_0000;
      pc_r       <= RESET_PC;
      instr_r    <= 32'h0000_0000;
      pc4_r      <= 32'h0000_0000;
      valid_r    <= 1'b0;
      fcnt_r     <= 32'h0000_0000;
      rcnt_r     <= 16'h0000;
    end else begin
      state_r    <= state_s;
      pend_tgt_r <= pend_tgt_s;
      pc_r       <= pc_s;
      instr_r    <= instr_s;
      pc4_r      <= pc4_s;
      valid_r    <= valid_s;
      fcnt_r     <= fcnt_s;
      rcnt_r     <= rcnt_s;
    end
  end

  assign bus.pc             = pc_r;
  assign bus.if_id_instr    = instr_r;
  assign bus.if_id_pc4      = pc4_r;
  assign bus.if_id_valid    = valid_r;
  assign bus.fetch_count    = fcnt_r;
  assign bus.redirect_count = rcnt_r;

endmodule

// File: tb/tb_if_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_stage
// Directed scenarios plus randomized traffic against a behavioural model of
// the fetch stage; outputs are compared on every falling edge.
// -----------------------------------------------------------------------------
module tb_if_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic clk;
  logic rst;
  logic fixed_mode;
  logic check_en;
  int   checks = 0;
  int   errors = 0;

  if_fetch_stage_if bus ();

  if_fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory contents: a fixed word or an address hash
  function automatic logic [31:0] imem(input logic [31:0] a, input logic fx);
    if (fx) return 32'h2008_0005;
    return (a * 32'h9E37_79B1) ^ 32'h0123_4567;
  endfunction

  assign bus.instr_in = imem(bus.pc, fixed_mode);

  // Behavioural model: totals kept as plain integers, counters derived from them
  logic [31:0] m_pc, m_instr, m_pc4, m_tgt;
  logic        m_valid, m_pend;
  longint      m_ftotal;
  longint      m_rtotal;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc <= RST_PC; m_instr <= 32'd0; m_pc4 <= 32'd0; m_valid <= 1'b0;
      m_ftotal <= 0; m_rtotal <= 0; m_pend <= 1'b0; m_tgt <= 32'd0;
    end else if (bus.redirect && bus.pc_enable) begin
      m_pc <= (bus.redirect_target / 32'd4) * 32'd4;
      m_instr <= 32'd0; m_pc4 <= 32'd0; m_valid <= 1'b0;
      m_pend <= 1'b0; m_rtotal <= m_rtotal + 1;
    end else if (bus.redirect) begin
      m_tgt <= (bus.redirect_target / 32'd4) * 32'd4; m_pend <= 1'b1;
      m_instr <= 32'd0; m_pc4 <= 32'd0; m_valid <= 1'b0;
    end else if (m_pend && bus.pc_enable) begin
      m_pc <= m_tgt; m_pend <= 1'b0; m_rtotal <= m_rtotal + 1;
      m_instr <= 32'd0; m_pc4 <= 32'd0; m_valid <= 1'b0;
    end else if (!bus.pc_enable || bus.stall) begin
      m_pc <= m_pc;
    end else begin
      m_instr <= imem(m_pc, fixed_mode);
      m_pc4 <= m_pc + 32'd4; m_pc <= m_pc + 32'd4;
      m_valid <= 1'b1; m_ftotal <= m_ftotal + 1;
    end
  end

  function automatic logic [31:0] exp_fcnt();
    longint t;
    t = m_ftotal;
    return t[31:0];
  endfunction

  function automatic logic [15:0] exp_rcnt();
    longint t;
    t = m_rtotal;
    if (t > 65535) return 16'hFFFF;
    return t[15:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (check_en && !rst) begin
      check("pc", bus.pc, m_pc);
      check("if_id_instr", bus.if_id_instr, m_instr);
      check("if_id_pc4", bus.if_id_pc4, m_pc4);
      check("if_id_valid", {31'd0, bus.if_id_valid}, {31'd0, m_valid});
      check("fetch_count", bus.fetch_count, exp_fcnt());
      check("redirect_count", {16'd0, bus.redirect_count}, {16'd0, exp_rcnt()});
    end
  end

  task automatic cyc(input logic en, input logic st, input logic rd, input logic [31:0] t);
    bus.pc_enable = en;
    bus.stall = st;
    bus.redirect = rd;
    bus.redirect_target = t;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; check_en = 1'b0; fixed_mode = 1'b1;
    bus.pc_enable = 1'b1; bus.stall = 1'b0; bus.redirect = 1'b0;
    bus.redirect_target = 32'd0;
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_pc", bus.pc, 32'h0);
    check("rst_valid", {31'd0, bus.if_id_valid}, 32'd0);
    check("rst_fcnt", bus.fetch_count, 32'd0);
    check("rst_rcnt", {16'd0, bus.redirect_count}, 32'd0);
    rst = 1'b0; check_en = 1'b1;

    // Free-run with a stall at pc=8
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    check("run_pc8", bus.pc, 32'd8);
    cyc(1'b1, 1'b1, 1'b0, 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 32'd0);
    check("stall_pc", bus.pc, 32'd8);
    check("stall_fcnt", bus.fetch_count, 32'd2);
    check("stall_pc4", bus.if_id_pc4, 32'd8);
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    check("run_pc12", bus.pc, 32'd12);
    check("run_pc4_12", bus.if_id_pc4, 32'd12);
    check("run_fcnt3", bus.fetch_count, 32'd3);
    check("run_instr", bus.if_id_instr, 32'h2008_0005);

    // Redirect beats stall, low target bits dropped
    cyc(1'b1, 1'b1, 1'b1, 32'h0000_0043);
    check("redir_pc", bus.pc, 32'h40);
    check("redir_valid", {31'd0, bus.if_id_valid}, 32'd0);
    check("redir_rcnt", {16'd0, bus.redirect_count}, 32'd1);

    // Reach pc=20 with a valid IF/ID, then halt with a redirect
    cyc(1'b1, 1'b0, 1'b1, 32'h0000_0010);
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    check("pre_halt_pc", bus.pc, 32'd20);
    cyc(1'b0, 1'b0, 1'b1, 32'h0000_0100);
    check("halt_pc", bus.pc, 32'd20);
    check("halt_valid", {31'd0, bus.if_id_valid}, 32'd0);
    check("halt_rcnt", {16'd0, bus.redirect_count}, 32'd2);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    check("halt_hold_pc", bus.pc, 32'd20);
    cyc(1'b1, 1'b1, 1'b0, 32'd0);
    check("resume_pc", bus.pc, 32'h100);
    check("resume_rcnt", {16'd0, bus.redirect_count}, 32'd3);

    // PC wrap
    cyc(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
    check("wrap_tgt", bus.pc, 32'hFFFF_FFFC);
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    check("wrap_pc", bus.pc, 32'd0);
    check("wrap_pc4", bus.if_id_pc4, 32'd0);
    check("wrap_fcnt", bus.fetch_count, 32'd5);

    // Async reset between edges while a redirect is parked
    cyc(1'b0, 1'b0, 1'b1, 32'h0000_0200);
    #2 rst = 1'b1;
    #1;
    check("arst_pc", bus.pc, RST_PC);
    check("arst_valid", {31'd0, bus.if_id_valid}, 32'd0);
    check("arst_pc4", bus.if_id_pc4, 32'd0);
    check("arst_fcnt", bus.fetch_count, 32'd0);
    check("arst_rcnt", {16'd0, bus.redirect_count}, 32'd0);
    bus.pc_enable = 1'b1; bus.redirect = 1'b0; bus.stall = 1'b0;
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("post_arst_pc", bus.pc, RST_PC + 32'd4);
    check("post_arst_rcnt", {16'd0, bus.redirect_count}, 32'd0);

    // Randomized traffic
    fixed_mode = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 9) != 0), ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 7) == 0), $urandom);
    end

    // Redirect-counter saturation from a clean reset
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    for (int i = 0; i < 65535; i++) begin
      cyc(1'b1, 1'b0, 1'b1, $urandom);
    end
    check("sat_reach", {16'd0, bus.redirect_count}, 32'h0000_FFFF);
    cyc(1'b1, 1'b0, 1'b1, $urandom);
    cyc(1'b1, 1'b0, 1'b1, $urandom);
    check("sat_hold", {16'd0, bus.redirect_count}, 32'h0000_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the pipelined MIPS CPU: owns the program counter, drives the instruction-memory address, and loads the IF/ID pipeline register. It consumes the active-high `pc_enable` from the syscall halt controller directly upstream, along with hazard stalls from ID and branch/jump redirects from EX. A redirect that arrives while the CPU is halted is held and applied on resume. Fetch and redirect counters feed the board display.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `pc_enable` input 1: 1 = run, 0 = halted. Driven by the halt controller and changes on the falling edge of `clk`.
- `stall` input 1: load-use hazard from ID; holds PC and IF/ID.
- `redirect` input 1: taken branch, jump or jr resolved in EX.
- `redirect_target` input 32: new PC; bits [1:0] are ignored and treated as 00.
- `instr_in` input 32: combinational instruction-memory read data for `pc`.
- `pc` output 32: current fetch address to instruction memory.
- `if_id_instr` output 32: IF/ID instruction.
- `if_id_pc4` output 32: IF/ID PC+4.
- `if_id_valid` output 1: IF/ID holds a real instruction.
- `fetch_count` output 32: number of instructions loaded into IF/ID; wraps modulo 2^32.
- `redirect_count` output 16: number of redirects applied to the PC; saturates at 16'hFFFF.

## Operation
- **Reset values (immediate, asynchronous):**
  - `pc` = `RESET_PC`
  - `if_id_instr` = 0, `if_id_pc4` = 0, `if_id_valid` = 0
  - `fetch_count` = 0, `redirect_count` = 0
  - Pending-redirect flag = 0, pending target = 0.
- **Priority at each rising edge, first match wins:**
  1. `redirect`=1 and `pc_enable`=1:
     - `pc` <= {target[31:2],2'b00}
     - IF/ID flushed: instr 0, pc4 0, valid 0
     - Pending flag cleared; `redirect_count` += 1.
  2. `redirect`=1 and `pc_enable`=0:
     - Target is captured into the pending register and the pending flag is set. A newer redirect overwrites an older pending one.
     - IF/ID is flushed immediately.
     - `pc` holds; `redirect_count` is unchanged.
  3. Pending flag=1 and `pc_enable`=1:
     - `pc` <= pending target; IF/ID flushed.
     - Pending flag cleared; `redirect_count` += 1.
     - `stall` is ignored on this edge.
  4. `pc_enable`=0: `pc`, IF/ID and counters all hold.
  5. `stall`=1: `pc`, IF/ID and counters all hold.
  6. Normal fetch:
     - `pc` <= `pc`+4
     - `if_id_instr` <= `instr_in`; `if_id_pc4` <= `pc`+4; `if_id_valid` <= 1
     - `fetch_count` += 1
- **Arithmetic:** PC+4 is 32-bit modulo; 32'hFFFF_FFFC advances to 0.
- **Counters:** `redirect_count` does not increment past 16'hFFFF. `fetch_count` wraps from 32'hFFFF_FFFF to 0.
- **Reset mid-operation:** the pending redirect is discarded.

## Timing
- `pc` is registered. Instruction memory is read combinationally, so `instr_in` is valid in the same cycle.
- Fetch latency: the instruction at `pc` appears on `if_id_instr` one rising edge later.
- Redirect latency: the target is on `pc` one edge after `redirect` is sampled high with `pc_enable`=1. The target instruction reaches IF/ID on the following edge. Exactly one bubble (`if_id_valid`=0) is inserted.
- `pc_enable` and `stall` are sampled only at rising edges. Because `pc_enable` is updated on falling edges, it is stable at every rising edge.
- Resume with a pending redirect: the first rising edge with `pc_enable`=1 loads the target.

## Test plan
- **Reset then free-run:** `rst` pulse with `RESET_PC`=0, `pc_enable`=1, `instr_in`=32'h2008_0005 -> after 3 edges `pc`=12, `if_id_pc4`=12, `if_id_valid`=1, `fetch_count`=3.
- **Stall:** raise `stall` for 2 cycles at `pc`=8 -> `pc` stays 8 and IF/ID and `fetch_count` are unchanged. After release, the next edge gives `pc`=12.
- **Redirect vs stall:** `redirect`=1 with target 32'h0000_0043 and `stall`=1 in the same cycle -> `pc`=32'h40, `if_id_valid`=0, `redirect_count`=1.
- **Halt with pending redirect:** set `pc_enable`=0 at `pc`=20, then pulse `redirect` with target 32'h100 -> `if_id_valid`=0 at once and `pc` stays 20 while halted. On the first edge with `pc_enable`=1, `pc`=32'h100 and `redirect_count` += 1.
- **Wrap and saturation:** redirect to 32'hFFFF_FFFC, then one normal fetch -> `pc`=0, `if_id_pc4`=0. Force 65 537 redirects -> `redirect_count`=16'hFFFF.
- **Async reset mid-halt:** pending redirect set, assert `rst` between clock edges -> all outputs go to reset values immediately. After release with `pc_enable`=1, `pc` advances from `RESET_PC` and no pending target is applied.
